// File: rtl/axi_fifo_wr_scheduler_if.sv
// AXI4 write-channel bundle (AW, W, B) between the FIFO write scheduler and the DDR controller.
interface axi_fifo_wr_scheduler_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/axi_fifo_wr_scheduler.sv
// Round-robin scheduler draining per-channel video FIFOs into fixed-length AXI4 write bursts,
// with a per-channel frame offset that wraps at frame_bytes_i.
module axi_fifo_wr_scheduler #(
    parameter int CH_NUM     = 4,
    parameter int LVL_W      = 11,
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 28,
    parameter int BURST_LEN  = 16,
    parameter int BEAT_BYTES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_en_i,
    input  logic [CH_NUM*ADDR_W-1:0]   ch_base_addr_i,
    input  logic [ADDR_W-1:0]          frame_bytes_i,
    input  logic [CH_NUM*LVL_W-1:0]    fifo_rd_level_i,
    input  logic [CH_NUM*DATA_W-1:0]   fifo_rd_data_i,
    output logic [CH_NUM-1:0]          fifo_rd_en_o,
    axi_fifo_wr_scheduler_if.master    m_axi,
    output logic [CH_NUM-1:0]          frame_done_o,
    output logic                       bresp_err_o
);
    localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CNT_W = 9;
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BEAT_BYTES);
    localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_B} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, sel_s;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [CNT_W-1:0]    req_left_q, req_left_d, beat_cnt_q, beat_cnt_d;
    logic [CH_NUM-1:0]   frame_done_q, frame_done_d;
    logic                bresp_err_q, bresp_err_d;
    logic                inflight_q;
    logic [DATA_W-1:0]   skid_q [2];
    logic                skid_wr_q, skid_rd_q;
    logic [1:0]          skid_cnt_q;
    logic [ADDR_W-1:0]   offset_q [CH_NUM];

    logic [CH_NUM-1:0]   elig_s;
    logic                found_s, wvalid_s, wpop_s, wlast_s, rd_en_s, b_hs_s, wrap_s;
    logic [2:0]          skid_fill_s;
    logic [ADDR_W-1:0]   off_next_s;
    logic [DATA_W-1:0]   rd_data_s;
    int                  arb_idx_s;

    // Eligibility and round-robin search starting just after the last grant
    always_comb begin
        elig_s    = '0;
        found_s   = 1'b0;
        sel_s     = rr_ptr_q;
        arb_idx_s = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            elig_s[i] = fifo_rd_level_i[i*LVL_W +: LVL_W] >= LVL_W'(BURST_LEN);
        end
        for (int k = 1; k <= CH_NUM; k++) begin
            arb_idx_s = (int'(rr_ptr_q) + k) % CH_NUM;
            if (!found_s && elig_s[arb_idx_s[PTR_W-1:0]]) begin
                found_s = 1'b1;
                sel_s   = arb_idx_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Read-side flow control: the skid never holds more than two words including the one in flight
    always_comb begin
        wvalid_s    = (state_q == S_W) && (skid_cnt_q != 2'd0);
        wpop_s      = wvalid_s && m_axi.wready;
        wlast_s     = wvalid_s && (beat_cnt_q == LAST_BEAT);
        skid_fill_s = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, wpop_s};
        rd_en_s     = ((state_q == S_AW) || (state_q == S_W)) &&
                      (req_left_q != '0) && (skid_fill_s < 3'd2);
        b_hs_s      = (state_q == S_B) && m_axi.bvalid;
        off_next_s  = offset_q[gnt_q] + BURST_BYTES;
        wrap_s      = off_next_s >= frame_bytes_i;
        rd_data_s   = fifo_rd_data_i[gnt_q*DATA_W +: DATA_W];
    end

    // Burst sequencing: IDLE -> ARB -> AW -> W -> B -> IDLE
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        awaddr_d     = awaddr_q;
        req_left_d   = req_left_q - CNT_W'(rd_en_s);
        beat_cnt_d   = beat_cnt_q + CNT_W'(wpop_s);
        frame_done_d = '0;
        bresp_err_d  = bresp_err_q;
        case (state_q)
            S_IDLE: begin
                if (sched_en_i) state_d = S_ARB;
                else            state_d = S_IDLE;
            end
            S_ARB: begin
                if (found_s) begin
                    gnt_d      = sel_s;
                    rr_ptr_d   = sel_s;
                    awaddr_d   = ch_base_addr_i[sel_s*ADDR_W +: ADDR_W] + offset_q[sel_s];
                    req_left_d = CNT_W'(BURST_LEN);
                    beat_cnt_d = '0;
                    state_d    = S_AW;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_AW: begin
                if (m_axi.awready) state_d = S_W;
                else               state_d = S_AW;
            end
            S_W: begin
                if (wpop_s && wlast_s) state_d = S_B;
                else                   state_d = S_W;
            end
            S_B: begin
                if (m_axi.bvalid) begin
                    frame_done_d[gnt_q] = wrap_s;
                    bresp_err_d         = bresp_err_q | (m_axi.bresp != 2'b00);
                    state_d             = S_IDLE;
                end else begin
                    state_d             = S_B;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, skid buffer and per-channel offset registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= PTR_W'(CH_NUM - 1);
            gnt_q        <= '0;
            awaddr_q     <= '0;
            req_left_q   <= '0;
            beat_cnt_q   <= '0;
            frame_done_q <= '0;
            bresp_err_q  <= 1'b0;
            inflight_q   <= 1'b0;
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
            skid_wr_q    <= 1'b0;
            skid_rd_q    <= 1'b0;
            skid_cnt_q   <= 2'd0;
            for (int i = 0; i < CH_NUM; i++) offset_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            awaddr_q     <= awaddr_d;
            req_left_q   <= req_left_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_done_q <= frame_done_d;
            bresp_err_q  <= bresp_err_d;
            inflight_q   <= rd_en_s;
            skid_cnt_q   <= skid_cnt_q + 2'(inflight_q) - 2'(wpop_s);
            if (inflight_q) begin
                skid_q[skid_wr_q] <= rd_data_s;
                skid_wr_q         <= ~skid_wr_q;
            end
            if (wpop_s) skid_rd_q <= ~skid_rd_q;
            if (b_hs_s) offset_q[gnt_q] <= wrap_s ? '0 : off_next_s;
        end
    end

    assign fifo_rd_en_o  = rd_en_s ? (CH_NUM'(1'b1) << gnt_q) : '0;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = 8'(BURST_LEN - 1);
    assign m_axi.awvalid = (state_q == S_AW);
    assign m_axi.wdata   = skid_q[skid_rd_q];
    assign m_axi.wlast   = wlast_s;
    assign m_axi.wvalid  = wvalid_s;
    assign m_axi.bready  = (state_q == S_B);
    assign frame_done_o  = frame_done_q;
    assign bresp_err_o   = bresp_err_q;
endmodule
